line_sum_generator: RTL and testbench

- Producer side of the line-sum interface consumed by Line_sum_Accumulator.
- Streams pixel pairs (reference vs. test), one pair per accepted cycle.
- Computes each pair's squared difference and sums them over LINE_SIZE pixels.
- Emits one line_sum per completed line, with a valid pulse, line index and last-line-of-frame flag.

---
 rtl/line_sum_generator_pkg.sv | 16 +
 rtl/line_sum_generator_sq.sv | 37 +++
 rtl/line_sum_generator.sv | 101 ++++++++++
 tb/tb_line_sum_generator.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/line_sum_generator_pkg.sv
// Shared constants for the line-sum producer/consumer pair, so that both sides
// always agree on the pixel, line and line-sum widths.
package line_sum_generator_pkg;
  localparam int PIXEL_SIZE   = 8;
  localparam int LINE_SIZE    = 8;
  localparam int NUM_OF_LINES = 4;
  localparam int SUM_W        = $clog2(LINE_SIZE) + 2 * PIXEL_SIZE;
  localparam int SQ_W         = 2 * PIXEL_SIZE;
  localparam int PCNT_W       = (LINE_SIZE > 1) ? $clog2(LINE_SIZE) : 1;
  localparam int LIDX_W       = (NUM_OF_LINES > 1) ? $clog2(NUM_OF_LINES) : 1;

  function automatic logic [PIXEL_SIZE-1:0] abs_diff(input logic [PIXEL_SIZE-1:0] a,
                                                     input logic [PIXEL_SIZE-1:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction
endpackage

// File: rtl/line_sum_generator_sq.sv
// pixel_sq_diff: registers |a-b| with its valid/last tags; the square is
// combinational off the registered difference.
module pixel_sq_diff
  import line_sum_generator_pkg::*;
(
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  in_valid_i,
  input  logic                  in_last_i,
  input  logic [PIXEL_SIZE-1:0] a_i,
  input  logic [PIXEL_SIZE-1:0] b_i,
  output logic                  diff_valid_o,
  output logic                  diff_last_o,
  output logic [SQ_W-1:0]       sq_o
);
  logic [PIXEL_SIZE-1:0] diff_q;
  logic                  valid_q;
  logic                  last_q;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      diff_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= in_valid_i;
      if (in_valid_i) begin
        diff_q <= abs_diff(a_i, b_i);
        last_q <= in_last_i;
      end
    end
  end

  assign diff_valid_o = valid_q;
  assign diff_last_o  = last_q;
  assign sq_o         = SQ_W'(diff_q) * SQ_W'(diff_q);
endmodule

// File: rtl/line_sum_generator.sv
// Streams reference/test pixel pairs and emits the sum of squared differences
// for every completed line, tagged with the line index and end-of-frame flag.
module line_sum_generator
  import line_sum_generator_pkg::*;
(
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pix_valid,
  input  logic [PIXEL_SIZE-1:0] pix_a,
  input  logic [PIXEL_SIZE-1:0] pix_b,
  output logic [SUM_W-1:0]      line_sum,
  output logic                  line_valid,
  output logic [LIDX_W-1:0]     line_idx,
  output logic                  frame_last
);
  localparam logic [PCNT_W-1:0] PIX_LAST  = PCNT_W'(LINE_SIZE - 1);
  localparam logic [LIDX_W-1:0] LINE_LAST = LIDX_W'(NUM_OF_LINES - 1);

  logic [PCNT_W-1:0] pix_cnt_q, pix_cnt_d, pix_base;
  logic [LIDX_W-1:0] line_cnt_q, line_cnt_d;
  logic [SUM_W-1:0]  acc_q, acc_d, acc_sum;
  logic [SUM_W-1:0]  line_sum_q, line_sum_d;
  logic              line_valid_q, line_valid_d;
  logic [LIDX_W-1:0] line_idx_q, line_idx_d;
  logic              frame_last_q, frame_last_d;
  logic              in_last;
  logic              s1_valid, s1_last;
  logic [SQ_W-1:0]   s1_sq;

  // A pixel arriving with start is pixel 0, so the count restarts before use.
  assign pix_base = start ? '0 : pix_cnt_q;
  assign in_last  = (pix_base == PIX_LAST);

  pixel_sq_diff u_sq (
    .CLK         (CLK),
    .reset       (reset),
    .in_valid_i  (pix_valid),
    .in_last_i   (in_last),
    .a_i         (pix_a),
    .b_i         (pix_b),
    .diff_valid_o(s1_valid),
    .diff_last_o (s1_last),
    .sq_o        (s1_sq)
  );

  assign acc_sum = acc_q + SUM_W'(s1_sq);

  always_comb begin
    pix_cnt_d    = pix_base;
    acc_d        = acc_q;
    line_cnt_d   = line_cnt_q;
    line_sum_d   = line_sum_q;
    line_valid_d = 1'b0;
    line_idx_d   = line_idx_q;
    frame_last_d = frame_last_q;
    if (pix_valid)
      pix_cnt_d = in_last ? '0 : pix_base + 1'b1;
    // start drops whatever stage 2 holds, including a pending line pulse.
    if (start) begin
      acc_d      = '0;
      line_cnt_d = '0;
    end else if (s1_valid) begin
      if (s1_last) begin
        line_sum_d   = acc_sum;
        acc_d        = '0;
        line_valid_d = 1'b1;
        line_idx_d   = line_cnt_q;
        frame_last_d = (line_cnt_q == LINE_LAST);
        line_cnt_d   = (line_cnt_q == LINE_LAST) ? '0 : line_cnt_q + 1'b1;
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      acc_q        <= '0;
      line_sum_q   <= '0;
      line_valid_q <= 1'b0;
      line_idx_q   <= '0;
      frame_last_q <= 1'b0;
    end else begin
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      acc_q        <= acc_d;
      line_sum_q   <= line_sum_d;
      line_valid_q <= line_valid_d;
      line_idx_q   <= line_idx_d;
      frame_last_q <= frame_last_d;
    end
  end

  assign line_sum   = line_sum_q;
  assign line_valid = line_valid_q;
  assign line_idx   = line_idx_q;
  assign frame_last = frame_last_q;
endmodule

// File: tb/tb_line_sum_generator.sv
// Directed bench for line_sum_generator: hand-computed line sums, pulse timing,
// bubbles, frame wrap, mid-line reset and start behaviour.
module tb_line_sum_generator;
  import line_sum_generator_pkg::*;

  logic                  CLK = 1'b0;
  logic                  reset;
  logic                  start;
  logic                  pix_valid;
  logic [PIXEL_SIZE-1:0] pix_a, pix_b;
  logic [SUM_W-1:0]      line_sum;
  logic                  line_valid;
  logic [LIDX_W-1:0]     line_idx;
  logic                  frame_last;

  int tests = 0;
  int fails = 0;

  line_sum_generator dut (
    .CLK       (CLK),
    .reset     (reset),
    .start     (start),
    .pix_valid (pix_valid),
    .pix_a     (pix_a),
    .pix_b     (pix_b),
    .line_sum  (line_sum),
    .line_valid(line_valid),
    .line_idx  (line_idx),
    .frame_last(frame_last)
  );

  always #5 CLK = ~CLK;

  // Drive one cycle of inputs; returns 1 ns after the edge that samples them.
  task automatic cyc(input logic v, input logic [PIXEL_SIZE-1:0] a,
                     input logic [PIXEL_SIZE-1:0] b, input logic st);
    pix_valid = v; pix_a = a; pix_b = b; start = st;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_a = '0; pix_b = '0;
    #2 reset = 1'b0;
    #1;
    tests++; if (line_sum !== '0) begin fails++; $display("FAIL reset_sum: got %0d expected 0", line_sum); end
    tests++; if (line_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b expected 0", line_valid); end
    tests++; if (line_idx !== '0) begin fails++; $display("FAIL reset_idx: got %0d expected 0", line_idx); end
    tests++; if (frame_last !== 1'b0) begin fails++; $display("FAIL reset_flast: got %0b expected 0", frame_last); end
    @(posedge CLK); @(posedge CLK); #1;
    reset = 1'b1;
  endtask

  // 8 x (10-7)^2 = 72; pulse visible after the second edge counted from the
  // edge that samples the 8th pixel.
  task automatic test_basic_line;
    int early = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'd10, 8'd7, 1'b0);
      if (line_valid) early++;
    end
    tests++; if (early != 0) begin fails++; $display("FAIL basic_early: got %0d pulses expected 0", early); end
    cyc(1'b0, 8'd0, 8'd0, 1'b0);
    tests++; if (line_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %0b expected 1", line_valid); end
    tests++; if (line_sum !== 19'd72) begin fails++; $display("FAIL basic_sum: got %0d expected 72", line_sum); end
    tests++; if (line_idx !== 2'd0) begin fails++; $display("FAIL basic_idx: got %0d expected 0", line_idx); end
    tests++; if (frame_last !== 1'b0) begin fails++; $display("FAIL basic_flast: got %0b expected 0", frame_last); end
    cyc(1'b0, 8'd0, 8'd0, 1'b0);
    tests++; if (line_valid !== 1'b0) begin fails++; $display("FAIL basic_one_cycle: got %0b expected 0", line_valid); end
    tests++; if (line_sum !== 19'd72) begin fails++; $display("FAIL basic_hold: got %0d expected 72", line_sum); end
  endtask

  // 8 x 255^2 = 520200, needs all 19 bits.
  task automatic test_max_line;
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'd0, 8'd255, 1'b0);
    cyc(1'b0, 8'd0, 8'd0, 1'b0);
    tests++; if (line_valid !== 1'b1) begin fails++; $display("FAIL max_valid: got %0b expected 1", line_valid); end
    tests++; if (line_sum !== 19'd520200) begin fails++; $display("FAIL max_sum: got %0d expected 520200", line_sum); end
    tests++; if (line_idx !== 2'd1) begin fails++; $display("FAIL max_idx: got %0d expected 1", line_idx); end
  endtask

  // Valid on even cycles only; 8th accepted pixel at i=14, pulse seen at i=15.
  task automatic test_bubbles;
    int npulse = 0;
    int at = -1;
    for (int i = 0; i < 20; i++) begin
      cyc((i % 2 == 0) && (i < 16), 8'(i + 1), 8'(i), 1'b0);
      if (line_valid) begin
        npulse++; at = i;
        tests++; if (line_sum !== 19'd8) begin fails++; $display("FAIL bubble_sum: got %0d expected 8", line_sum); end
        tests++; if (line_idx !== 2'd2) begin fails++; $display("FAIL bubble_idx: got %0d expected 2", line_idx); end
      end
    end
    tests++; if (npulse != 1) begin fails++; $display("FAIL bubble_count: got %0d expected 1", npulse); end
    tests++; if (at != 15) begin fails++; $display("FAIL bubble_time: got %0d expected 15", at); end
  endtask

  // Four back-to-back lines of 8 x (3-1)^2 = 32, then a fifth wrapping to idx 0.
  task automatic test_back_to_back;
    int npulse = 0;
    cyc(1'b0, 8'd0, 8'd0, 1'b1);
    for (int i = 0; i < 42; i++) begin
      cyc(i < 40, 8'd3, 8'd1, 1'b0);
      if (line_valid) begin
        tests++; if (i != 8 * npulse + 8) begin fails++; $display("FAIL b2b_time: got %0d expected %0d", i, 8 * npulse + 8); end
        tests++; if (line_sum !== 19'd32) begin fails++; $display("FAIL b2b_sum: got %0d expected 32", line_sum); end
        tests++; if (line_idx !== 2'(npulse % 4)) begin fails++; $display("FAIL b2b_idx: got %0d expected %0d", line_idx, npulse % 4); end
        tests++; if (frame_last !== (npulse % 4 == 3)) begin fails++; $display("FAIL b2b_flast: got %0b expected %0b", frame_last, npulse % 4 == 3); end
        npulse++;
      end
    end
    tests++; if (npulse != 5) begin fails++; $display("FAIL b2b_count: got %0d expected 5", npulse); end
  endtask

  // Aborted partial line (5 x 64) must leave no residue in the next line.
  task automatic test_reset_midline;
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'd9, 8'd1, 1'b0);
    reset = 1'b0;
    #1;
    tests++; if (line_sum !== '0) begin fails++; $display("FAIL midrst_sum: got %0d expected 0", line_sum); end
    tests++; if (line_valid !== 1'b0 || line_idx !== '0 || frame_last !== 1'b0) begin
      fails++; $display("FAIL midrst_outs: got v=%0b idx=%0d fl=%0b expected 0/0/0", line_valid, line_idx, frame_last);
    end
    cyc(1'b0, 8'd0, 8'd0, 1'b0);
    cyc(1'b0, 8'd0, 8'd0, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'd2, 8'd0, 1'b0);
    cyc(1'b0, 8'd0, 8'd0, 1'b0);
    tests++; if (line_valid !== 1'b1) begin fails++; $display("FAIL midrst_valid: got %0b expected 1", line_valid); end
    tests++; if (line_sum !== 19'd32) begin fails++; $display("FAIL midrst_line_sum: got %0d expected 32", line_sum); end
    tests++; if (line_idx !== 2'd0) begin fails++; $display("FAIL midrst_idx: got %0d expected 0", line_idx); end
  endtask

  // Line 1 completes, 3 pixels of line 2, then start+pixel: new pixel 0 of line 0.
  task automatic test_start_midline;
    int npulse = 0;
    int at = -1;
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'd1, 8'd0, 1'b0);
    cyc(1'b0, 8'd0, 8'd0, 1'b0);
    tests++; if (line_idx !== 2'd1 || line_sum !== 19'd8) begin
      fails++; $display("FAIL startmid_pre: got idx=%0d sum=%0d expected 1/8", line_idx, line_sum);
    end
    for (int i = 0; i < 14; i++) begin
      if (i < 3)       cyc(1'b1, 8'd5, 8'd0, 1'b0);
      else if (i == 3) cyc(1'b1, 8'd4, 8'd2, 1'b1);
      else             cyc(i < 11, 8'd4, 8'd2, 1'b0);
      if (line_valid) begin
        npulse++; at = i;
        tests++; if (line_sum !== 19'd32) begin fails++; $display("FAIL startmid_sum: got %0d expected 32", line_sum); end
        tests++; if (line_idx !== 2'd0) begin fails++; $display("FAIL startmid_idx: got %0d expected 0", line_idx); end
      end
    end
    tests++; if (npulse != 1) begin fails++; $display("FAIL startmid_count: got %0d expected 1", npulse); end
    tests++; if (at != 11) begin fails++; $display("FAIL startmid_time: got %0d expected 11", at); end
  endtask

  // start on the cycle a completed line would be reported drops that pulse.
  task automatic test_start_suppress;
    int npulse = 0;
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'd1, 8'd0, 1'b0);
    cyc(1'b0, 8'd0, 8'd0, 1'b1);
    if (line_valid) npulse++;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'd0, 8'd0, 1'b0);
      if (line_valid) npulse++;
    end
    tests++; if (npulse != 0) begin fails++; $display("FAIL suppress_count: got %0d expected 0", npulse); end
    tests++; if (line_sum !== 19'd32) begin fails++; $display("FAIL suppress_hold: got %0d expected 32", line_sum); end
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'd6, 8'd4, 1'b0);
    cyc(1'b0, 8'd0, 8'd0, 1'b0);
    tests++; if (line_valid !== 1'b1 || line_sum !== 19'd32 || line_idx !== 2'd0) begin
      fails++; $display("FAIL suppress_next: got v=%0b sum=%0d idx=%0d expected 1/32/0", line_valid, line_sum, line_idx);
    end
  endtask

  initial begin
    test_reset();
    test_basic_line();
    test_max_line();
    test_bubbles();
    test_back_to_back();
    test_reset_midline();
    test_start_midline();
    test_start_suppress();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
